roomba_drive_seq: RTL and testbench

//  Bump-stop drive sequencer for the two-wheel roomba. Drives forward until a bumper closes, then

---
 rtl/roomba_drive_seq_pkg.sv | 28 ++
 rtl/roomba_drive_seq_sync.sv | 33 +++
 rtl/roomba_drive_seq.sv | 166 ++++++++++++++++
 tb/tb_roomba_drive_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roomba_drive_seq_pkg.sv
// Shared definitions for the bump-stop drive sequencer: state codes,
// motor direction levels and the downstream pwm period.
package roomba_drive_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_PAUSE1 = 3'd2,
        ST_REV    = 3'd3,
        ST_PAUSE2 = 3'd4,
        ST_TURN   = 3'd5
    } drive_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // pwm period the timeon values are expressed against
    localparam int unsigned PWM_PERIOD = 16000;

    typedef struct packed {
        logic        motor_en;
        logic [15:0] timeon_l;
        logic [15:0] timeon_r;
        logic        dir_l;
        logic        dir_r;
    } drive_out_t;

endpackage

// File: rtl/roomba_drive_seq_sync.sv
// Two-flop synchroniser for asynchronous pins, with a one-cycle strobe on
// each rising edge of the synchronised level.
module sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         enable,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    // metastability stages plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!enable) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/roomba_drive_seq.sv
// Bump-stop drive sequencer: forward until a bumper closes, then pause,
// reverse and pivot away by encoder ticks (with a timeout), then resume.
module roomba_drive_seq
    import roomba_drive_seq_pkg::*;
#(
    parameter int unsigned DUTY_FWD    = 12000,
    parameter int unsigned DUTY_REV    = 8000,
    parameter int unsigned BACK_TICKS  = 20,
    parameter int unsigned TURN_TICKS  = 15,
    parameter int unsigned PAUSE_CYC   = 1600000,
    parameter int unsigned TIMEOUT_CYC = 8000000
) (
    input  logic        clk,
    input  logic        enable,
    input  logic        run,
    input  logic        bump_l,
    input  logic        bump_r,
    input  logic        enc_l,
    output logic [15:0] timeon_l,
    output logic [15:0] timeon_r,
    output logic        dir_l,
    output logic        dir_r,
    output logic        motor_en,
    output logic [2:0]  state,
    output logic        timeout
);

    localparam logic [7:0]  BACK_T     = 8'(BACK_TICKS);
    localparam logic [7:0]  TURN_T     = 8'(TURN_TICKS);
    localparam logic [23:0] PAUSE_LAST = 24'(PAUSE_CYC - 1);
    localparam logic [23:0] TO_LAST    = 24'(TIMEOUT_CYC - 1);

    logic [1:0]   bump_s;
    logic [1:0]   unused_bump_rise;
    logic         enc_tick;
    logic         unused_enc_level;

    drive_state_t st_q, nxt;
    logic [7:0]   tick_cnt, tick_nxt;
    logic [23:0]  cyc_cnt, cyc_inc;
    logic         to_hit, set_to;
    logic         turn_right;
    logic         bump_take;
    drive_out_t   out_q;

    sync_edge #(.W(2)) u_sync_bump (
        .clk    (clk),
        .enable (enable),
        .din    ({bump_r, bump_l}),
        .level  (bump_s),
        .rise   (unused_bump_rise)
    );

    sync_edge #(.W(1)) u_sync_enc (
        .clk    (clk),
        .enable (enable),
        .din    (enc_l),
        .level  (unused_enc_level),
        .rise   (enc_tick)
    );

    function automatic drive_out_t outputs_for(input drive_state_t s, input logic tr);
        drive_out_t o;
        o = '0;
        case (s)
            ST_FWD: begin
                o.motor_en = 1'b1;
                o.timeon_l = 16'(DUTY_FWD);
                o.timeon_r = 16'(DUTY_FWD);
                o.dir_l    = DIR_FWD;
                o.dir_r    = DIR_FWD;
            end
            ST_REV: begin
                o.motor_en = 1'b1;
                o.timeon_l = 16'(DUTY_REV);
                o.timeon_r = 16'(DUTY_REV);
                o.dir_l    = DIR_REV;
                o.dir_r    = DIR_REV;
            end
            ST_TURN: begin
                o.motor_en = 1'b1;
                o.timeon_l = 16'(DUTY_REV);
                o.timeon_r = 16'(DUTY_REV);
                o.dir_l    = tr ? DIR_FWD : DIR_REV;
                o.dir_r    = tr ? DIR_REV : DIR_FWD;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // next-state decision; the tick compare uses the count including this
    // cycle's tick so completion and timeout can coincide in one cycle
    always_comb begin
        nxt      = st_q;
        set_to   = 1'b0;
        tick_nxt = tick_cnt;
        if (enc_tick && tick_cnt != 8'hFF) begin
            tick_nxt = tick_cnt + 8'd1;
        end
        cyc_inc  = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 24'd1;
        to_hit   = (cyc_cnt == TO_LAST);
        if (!run) begin
            nxt = ST_IDLE;
        end else begin
            unique case (st_q)
                ST_IDLE:   nxt = ST_FWD;
                ST_FWD:    if (|bump_s) nxt = ST_PAUSE1;
                ST_PAUSE1: if (cyc_cnt == PAUSE_LAST) nxt = ST_REV;
                ST_REV: begin
                    if (tick_nxt == BACK_T || to_hit) begin
                        nxt    = ST_PAUSE2;
                        set_to = to_hit;
                    end
                end
                ST_PAUSE2: if (cyc_cnt == PAUSE_LAST) nxt = ST_TURN;
                ST_TURN: begin
                    if (tick_nxt == TURN_T || to_hit) begin
                        nxt    = ST_FWD;
                        set_to = to_hit;
                    end
                end
                default:   nxt = ST_IDLE;
            endcase
        end
    end

    assign bump_take = (st_q == ST_FWD) && (nxt == ST_PAUSE1);

    // state, counters, sticky timeout and outputs registered together so
    // outputs always describe the state held in st_q
    always_ff @(posedge clk) begin
        if (!enable) begin
            st_q       <= ST_IDLE;
            tick_cnt   <= '0;
            cyc_cnt    <= '0;
            turn_right <= 1'b0;
            timeout    <= 1'b0;
            out_q      <= '0;
        end else begin
            st_q <= nxt;
            if (nxt != st_q) begin
                tick_cnt <= '0;
                cyc_cnt  <= '0;
            end else begin
                tick_cnt <= (st_q == ST_REV || st_q == ST_TURN) ? tick_nxt : '0;
                cyc_cnt  <= (st_q inside {ST_PAUSE1, ST_REV, ST_PAUSE2, ST_TURN}) ? cyc_inc : '0;
            end
            if (set_to) begin
                timeout <= 1'b1;
            end
            if (bump_take) begin
                turn_right <= bump_s[0];
            end
            out_q <= outputs_for(nxt, turn_right);
        end
    end

    assign state    = st_q;
    assign motor_en = out_q.motor_en;
    assign timeon_l = out_q.timeon_l;
    assign timeon_r = out_q.timeon_r;
    assign dir_l    = out_q.dir_l;
    assign dir_r    = out_q.dir_r;

endmodule

// File: tb/tb_roomba_drive_seq.sv
// Self-checking bench for roomba_drive_seq: a directed vector table, a few
// hand-written manoeuvre sequences and a long randomized run, all checked
// cycle by cycle against a countdown-based reference model.
module tb_roomba_drive_seq;

    localparam int unsigned P_PAUSE = 100;
    localparam int unsigned P_TO    = 1000;
    localparam int unsigned P_BACK  = 4;
    localparam int unsigned P_TURN  = 3;

    logic        clk = 1'b0;
    logic        en = 1'b0, run = 1'b0, bl = 1'b0, br = 1'b0, enc = 1'b0;
    logic [15:0] timeon_l, timeon_r;
    logic        dir_l, dir_r, motor_en, timeout;
    logic [2:0]  state;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    roomba_drive_seq #(
        .DUTY_FWD    (12000),
        .DUTY_REV    (8000),
        .BACK_TICKS  (P_BACK),
        .TURN_TICKS  (P_TURN),
        .PAUSE_CYC   (P_PAUSE),
        .TIMEOUT_CYC (P_TO)
    ) dut (
        .clk      (clk),
        .enable   (en),
        .run      (run),
        .bump_l   (bl),
        .bump_r   (br),
        .enc_l    (enc),
        .timeon_l (timeon_l),
        .timeon_r (timeon_r),
        .dir_l    (dir_l),
        .dir_r    (dir_r),
        .motor_en (motor_en),
        .state    (state),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pins reach the sequencer two cycles late; an encoder tick is a rising
    // edge of that delayed pin. Phases are tracked with countdowns.
    int m_st = 0, m_wait = 0, m_ticks = 0, m_time = 0;
    bit m_tr = 0, m_to = 0;
    bit [2:0] hl = '0, hr = '0, he = '0;

    task automatic model_step();
        bit lvl_l, lvl_r, tk;
        if (!en) begin
            m_st = 0; m_tr = 0; m_to = 0;
            hl = '0; hr = '0; he = '0;
            return;
        end
        lvl_l = hl[1];
        lvl_r = hr[1];
        tk    = he[1] & ~he[2];
        if (!run) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (lvl_l | lvl_r) begin
                       m_tr = lvl_l; m_st = 2; m_wait = P_PAUSE;
                   end
                2, 4: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_st    = (m_st == 2) ? 3 : 5;
                        m_ticks = (m_st == 3) ? P_BACK : P_TURN;
                        m_time  = P_TO;
                    end
                end
                3, 5: begin
                    m_time--;
                    if (tk) m_ticks--;
                    if (m_ticks == 0 || m_time == 0) begin
                        if (m_time == 0) m_to = 1;
                        m_st = (m_st == 3) ? 4 : 1;
                        m_wait = P_PAUSE;
                    end
                end
                default: m_st = 0;
            endcase
        end
        hl = {hl[1:0], bl};
        hr = {hr[1:0], br};
        he = {he[1:0], enc};
    endtask

    function automatic logic [38:0] model_vec();
        logic        men;
        logic [15:0] t;
        logic        dl, dr;
        men = 0; t = 0; dl = 0; dr = 0;
        case (m_st)
            1: begin men = 1; t = 16'd12000; end
            3: begin men = 1; t = 16'd8000; dl = 1; dr = 1; end
            5: begin men = 1; t = 16'd8000; dl = ~m_tr; dr = m_tr; end
            default: ;
        endcase
        return {3'(m_st), men, t, t, dl, dr, m_to};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one clock, then update the model and compare the full output vector
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check("model", 64'({state, motor_en, timeon_l, timeon_r, dir_l, dir_r, timeout}),
              64'(model_vec()));
    endtask

    task automatic wait_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic pulses(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            enc = 1'b1; step();
            enc = 1'b0; step();
        end
    endtask

    task automatic bump_to_pause(input logic l, input logic r);
        bl = l; br = r; step();
        bl = 1'b0; br = 1'b0; wait_n(2);
        check("bump_pause.state", 64'(state), 64'd2);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en, run, bl, br;
        int unsigned pulses, cyc;
        logic [2:0]  st;
        logic        men;
        logic [15:0] ton_l, ton_r;
        logic        dl, dr, to;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic r, input logic l, input logic b,
                                input int unsigned p, input int unsigned c, input logic [2:0] s,
                                input logic m, input logic [15:0] tl, input logic [15:0] tr,
                                input logic dl, input logic dr, input logic to);
        vec_t v;
        v.en = e; v.run = r; v.bl = l; v.br = b; v.pulses = p; v.cyc = c;
        v.st = s; v.men = m; v.ton_l = tl; v.ton_r = tr; v.dl = dl; v.dr = dr; v.to = to;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        //             en run bl br pul cyc st men  ton_l   ton_r   dl dr to
        vecs[0]  = mk(0, 1, 0, 0, 0,  3, 0, 0, 16'd0,     16'd0,     0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0,  1, 1, 1, 16'd12000, 16'd12000, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0,  5, 1, 1, 16'd12000, 16'd12000, 0, 0, 0);
        vecs[3]  = mk(1, 1, 1, 0, 0,  1, 1, 1, 16'd12000, 16'd12000, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0,  2, 2, 0, 16'd0,     16'd0,     0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0, 99, 2, 0, 16'd0,     16'd0,     0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0,  1, 3, 1, 16'd8000,  16'd8000,  1, 1, 0);
        vecs[7]  = mk(1, 1, 0, 0, 3,  0, 3, 1, 16'd8000,  16'd8000,  1, 1, 0);
        vecs[8]  = mk(1, 1, 0, 0, 1,  1, 4, 0, 16'd0,     16'd0,     0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 99, 4, 0, 16'd0,     16'd0,     0, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 0,  1, 5, 1, 16'd8000,  16'd8000,  0, 1, 0);
        vecs[11] = mk(1, 1, 0, 0, 3,  1, 1, 1, 16'd12000, 16'd12000, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en; run = vecs[i].run; bl = vecs[i].bl; br = vecs[i].br;
            pulses(vecs[i].pulses);
            wait_n(vecs[i].cyc);
            check($sformatf("vec%0d.state", i),    64'(state),    64'(vecs[i].st));
            check($sformatf("vec%0d.motor_en", i), 64'(motor_en), 64'(vecs[i].men));
            check($sformatf("vec%0d.timeon_l", i), 64'(timeon_l), 64'(vecs[i].ton_l));
            check($sformatf("vec%0d.timeon_r", i), 64'(timeon_r), 64'(vecs[i].ton_r));
            check($sformatf("vec%0d.dir_l", i),    64'(dir_l),    64'(vecs[i].dl));
            check($sformatf("vec%0d.dir_r", i),    64'(dir_r),    64'(vecs[i].dr));
            check($sformatf("vec%0d.timeout", i),  64'(timeout),  64'(vecs[i].to));
        end

        // right bumper alone: pivot left
        bump_to_pause(1'b0, 1'b1);
        wait_n(P_PAUSE);
        check("bump_r.rev", 64'(state), 64'd3);
        pulses(P_BACK); step();
        check("bump_r.pause2", 64'(state), 64'd4);
        wait_n(P_PAUSE);
        check("bump_r.turn", 64'(state), 64'd5);
        check("bump_r.dir_l", 64'(dir_l), 64'd1);
        check("bump_r.dir_r", 64'(dir_r), 64'd0);
        pulses(P_TURN); step();
        check("bump_r.fwd", 64'(state), 64'd1);

        // both bumpers: pivot right
        bump_to_pause(1'b1, 1'b1);
        wait_n(P_PAUSE);
        pulses(P_BACK); step();
        wait_n(P_PAUSE);
        check("bump_lr.turn", 64'(state), 64'd5);
        check("bump_lr.dir_l", 64'(dir_l), 64'd0);
        check("bump_lr.dir_r", 64'(dir_r), 64'd1);
        pulses(P_TURN); step();
        check("bump_lr.fwd", 64'(state), 64'd1);

        // reverse without encoder pulses ends by timeout
        bump_to_pause(1'b1, 1'b0);
        wait_n(P_PAUSE);
        wait_n(P_TO - 1);
        check("to.still_rev", 64'(state), 64'd3);
        check("to.not_yet", 64'(timeout), 64'd0);
        step();
        check("to.pause2", 64'(state), 64'd4);
        check("to.flag", 64'(timeout), 64'd1);
        wait_n(P_PAUSE);
        pulses(P_TURN); step();
        check("to.fwd", 64'(state), 64'd1);
        check("to.sticky", 64'(timeout), 64'd1);

        // run dropped mid-reverse
        bump_to_pause(1'b1, 1'b0);
        wait_n(P_PAUSE + 10);
        check("run0.in_rev", 64'(state), 64'd3);
        run = 1'b0; step();
        check("run0.state", 64'(state), 64'd0);
        check("run0.motor_en", 64'(motor_en), 64'd0);
        check("run0.timeon_l", 64'(timeon_l), 64'd0);
        run = 1'b1; step();
        check("run1.state", 64'(state), 64'd1);
        check("run1.timeon_r", 64'(timeon_r), 64'd12000);

        // encoder pulses during the pause are not counted in reverse
        bump_to_pause(1'b1, 1'b0);
        pulses(5);
        wait_n(P_PAUSE - 10);
        check("pz.rev", 64'(state), 64'd3);
        pulses(P_BACK - 1); step();
        check("pz.rev_hold", 64'(state), 64'd3);
        pulses(1); step();
        check("pz.pause2", 64'(state), 64'd4);
        wait_n(P_PAUSE);
        pulses(1);
        check("pz.turn_to", 64'(timeout), 64'd1);
        en = 1'b0; step();
        check("rst.state", 64'(state), 64'd0);
        check("rst.timeout", 64'(timeout), 64'd0);
        check("rst.motor_en", 64'(motor_en), 64'd0);
        en = 1'b1;

        // randomized run; some segments without encoder to reach timeouts
        for (int s = 0; s < 24; s++) begin
            int unsigned enc_mode;
            enc_mode = $urandom_range(0, 2);
            for (int c = 0; c < 800; c++) begin
                en  = ($urandom_range(0, 1999) != 0);
                run = ($urandom_range(0, 699) != 0);
                bl  = ($urandom_range(0, 149) == 0);
                br  = ($urandom_range(0, 149) == 0);
                if (enc_mode == 0) enc = 1'b0;
                else if (enc_mode == 1) enc = $urandom_range(0, 1) != 0;
                else enc = ($urandom_range(0, 19) == 0) ? ~enc : enc;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
